// File: rtl/mxbus_sram_ctrl.sv
// MX Bus dual-port SRAM slave: strobed writes, pipelined reads, range errors, post-reset init sweep.
// Optional macro MXBUS_SRAM_BYPASS_EN forwards a same-cycle write into a same-address read.
module mxbus_sram_ctrl #(
   parameter int                    ADDR_WIDTH = 8,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    DEPTH      = 256,
   parameter int                    RD_LATENCY = 1,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    s0_wr_txn_start,
   input  logic [ADDR_WIDTH-1:0]   s0_wr_addr,
   input  logic [DATA_WIDTH-1:0]   s0_wr_data,
   input  logic [DATA_WIDTH/8-1:0] s0_wr_strb,
   output logic                    s0_wr_ready,
   output logic                    s0_wr_txn_ack,
   output logic                    s0_wr_txn_cpl,
   output logic                    s0_wr_err,
   input  logic                    s0_rd_txn_start,
   input  logic [ADDR_WIDTH-1:0]   s0_rd_addr,
   output logic [DATA_WIDTH-1:0]   s0_rd_data,
   output logic                    s0_rd_ready,
   output logic                    s0_rd_txn_ack,
   output logic                    s0_rd_txn_cpl,
   output logic                    s0_rd_err,
   output logic                    init_done
);

   localparam int STRB_W = DATA_WIDTH / 8;
   localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH + 1)'(DEPTH);
   localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(DEPTH - 1);

   if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0 || DEPTH < 1 || DEPTH > (2 ** ADDR_WIDTH) ||
       RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_param_err
      $error("mxbus_sram_ctrl: illegal DATA_WIDTH, DEPTH or RD_LATENCY");
   end

   typedef enum logic {ST_INIT, ST_RUN} state_e;

   state_e                  state_q, state_d;
   logic [IDX_W-1:0]        cnt_q, cnt_d;
   logic                    ready_q, ready_d;
   logic                    wr_ack_q, wr_ack_d;
   logic                    wr_err_q, wr_err_d;
   logic                    rd_ack_q, rd_ack_d;
   logic [RD_LATENCY-1:0]   rd_vld_q, rd_vld_d;
   logic [RD_LATENCY-1:0]   rd_err_q, rd_err_d;
   logic [DATA_WIDTH-1:0]   rd_data_q [RD_LATENCY];
   logic [DATA_WIDTH-1:0]   rd_data_d [RD_LATENCY];

   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic                    wr_acc, wr_in_range;
   logic                    rd_acc, rd_in_range;
   logic [IDX_W-1:0]        wr_idx, rd_idx;
   logic                    mem_we;
   logic [IDX_W-1:0]        mem_idx;
   logic [DATA_WIDTH-1:0]   mem_wdata;
   logic [STRB_W-1:0]       mem_wstrb;
   logic [DATA_WIDTH-1:0]   rd_word;

   always_comb begin
      wr_acc      = s0_wr_txn_start && (state_q == ST_RUN);
      rd_acc      = s0_rd_txn_start && (state_q == ST_RUN);
      wr_in_range = {1'b0, s0_wr_addr} < DEPTH_L;
      rd_in_range = {1'b0, s0_rd_addr} < DEPTH_L;
      wr_idx      = IDX_W'(s0_wr_addr);
      rd_idx      = IDX_W'(s0_rd_addr);
   end

   // The init sweep owns the write port until RUN; bus writes only land in range.
   always_comb begin
      mem_we    = 1'b0;
      mem_idx   = wr_idx;
      mem_wdata = s0_wr_data;
      mem_wstrb = s0_wr_strb;
      if (state_q == ST_INIT) begin
         mem_we    = 1'b1;
         mem_idx   = cnt_q;
         mem_wdata = INIT_VALUE;
         mem_wstrb = '1;
      end else if (wr_acc && wr_in_range) begin
         mem_we = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (mem_wstrb[i]) mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
         end
      end
   end

   always_comb begin
      rd_word = mem[rd_idx];
`ifdef MXBUS_SRAM_BYPASS_EN
      if (wr_acc && wr_in_range && (s0_wr_addr == s0_rd_addr)) begin
         for (int i = 0; i < STRB_W; i++) begin
            if (s0_wr_strb[i]) rd_word[8*i +: 8] = s0_wr_data[8*i +: 8];
         end
      end
`endif
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ready_d = ready_q;
      case (state_q)
         ST_INIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) begin
               state_d = ST_RUN;
               ready_d = 1'b1;
               cnt_d   = '0;
            end
         end
         default: begin
            ready_d = 1'b1;
         end
      endcase
   end

   // Stage data is forced to zero for idle or out-of-range slots so the output needs no gating.
   always_comb begin
      wr_ack_d     = wr_acc;
      wr_err_d     = wr_acc && !wr_in_range;
      rd_ack_d     = rd_acc;
      rd_vld_d     = '0;
      rd_err_d     = '0;
      rd_vld_d[0]  = rd_acc;
      rd_err_d[0]  = rd_acc && !rd_in_range;
      rd_data_d[0] = (rd_acc && rd_in_range) ? rd_word : '0;
      for (int i = 1; i < RD_LATENCY; i++) begin
         rd_vld_d[i]  = rd_vld_q[i-1];
         rd_err_d[i]  = rd_err_q[i-1];
         rd_data_d[i] = rd_data_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_INIT;
         cnt_q    <= '0;
         ready_q  <= 1'b0;
         wr_ack_q <= 1'b0;
         wr_err_q <= 1'b0;
         rd_ack_q <= 1'b0;
         rd_vld_q <= '0;
         rd_err_q <= '0;
         for (int i = 0; i < RD_LATENCY; i++) rd_data_q[i] <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ready_q  <= ready_d;
         wr_ack_q <= wr_ack_d;
         wr_err_q <= wr_err_d;
         rd_ack_q <= rd_ack_d;
         rd_vld_q <= rd_vld_d;
         rd_err_q <= rd_err_d;
         for (int i = 0; i < RD_LATENCY; i++) rd_data_q[i] <= rd_data_d[i];
      end
   end

   assign s0_wr_ready   = ready_q;
   assign s0_rd_ready   = ready_q;
   assign init_done     = ready_q;
   assign s0_wr_txn_ack = wr_ack_q;
   assign s0_wr_txn_cpl = wr_ack_q;
   assign s0_wr_err     = wr_err_q;
   assign s0_rd_txn_ack = rd_ack_q;
   assign s0_rd_txn_cpl = rd_vld_q[RD_LATENCY-1];
   assign s0_rd_err     = rd_err_q[RD_LATENCY-1];
   assign s0_rd_data    = rd_data_q[RD_LATENCY-1];

endmodule

// File: tb/tb_mxbus_sram_ctrl.sv
// Bench for mxbus_sram_ctrl: transaction-level memory model with a per-cycle compare, plus directed literal checks.
module tb_mxbus_sram_ctrl;

   localparam int AW    = 8;
   localparam int DW    = 32;
   localparam int DEPTH = 200;
   localparam int LAT   = 3;
   localparam logic [DW-1:0] INIT = 32'hA5A5A5A5;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          wr_start = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic [3:0]    wr_strb = '0;
   logic          rd_start = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic          wr_ready, wr_ack, wr_cpl, wr_err;
   logic [DW-1:0] rd_data;
   logic          rd_ready, rd_ack, rd_cpl, rd_err, init_done;

   int total = 0;
   int bad   = 0;

   mxbus_sram_ctrl #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RD_LATENCY(LAT), .INIT_VALUE(INIT)
   ) dut (
      .clk(clk), .rst(rst),
      .s0_wr_txn_start(wr_start), .s0_wr_addr(wr_addr), .s0_wr_data(wr_data), .s0_wr_strb(wr_strb),
      .s0_wr_ready(wr_ready), .s0_wr_txn_ack(wr_ack), .s0_wr_txn_cpl(wr_cpl), .s0_wr_err(wr_err),
      .s0_rd_txn_start(rd_start), .s0_rd_addr(rd_addr), .s0_rd_data(rd_data), .s0_rd_ready(rd_ready),
      .s0_rd_txn_ack(rd_ack), .s0_rd_txn_cpl(rd_cpl), .s0_rd_err(rd_err), .init_done(init_done)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                           input logic [3:0] strb);
      logic [DW-1:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++) if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
      return r;
   endfunction

   // behavioural model: memory image, readiness after DEPTH post-reset edges, queue of due completions
   typedef struct {
      int            due;
      logic [DW-1:0] data;
      logic          err;
   } rd_t;

   logic [DW-1:0] mm [256];
   rd_t           rq[$];
   int            cyc = 0;
   int            since_rel = 0;
   bit            rdy_m = 1'b0;
   bit            e_wr_ack = 1'b0, e_wr_err = 1'b0, e_rd_ack = 1'b0;

   initial begin
      forever begin
         @(posedge clk or negedge rst);
         if (!rst) begin
            rq.delete();
            rdy_m = 1'b0; since_rel = 0;
            e_wr_ack = 1'b0; e_wr_err = 1'b0; e_rd_ack = 1'b0;
         end else begin
            cyc++;
            while (rq.size() > 0 && rq[0].due < cyc) void'(rq.pop_front());
            e_wr_ack = 1'b0; e_wr_err = 1'b0; e_rd_ack = 1'b0;
            if (rdy_m) begin
               if (rd_start) begin
                  rd_t t;
                  t.err  = (int'(rd_addr) >= DEPTH);
                  t.data = t.err ? '0 : mm[rd_addr];
`ifdef MXBUS_SRAM_BYPASS_EN
                  if (wr_start && wr_addr == rd_addr && !t.err) t.data = merge(t.data, wr_data, wr_strb);
`endif
                  t.due = cyc + LAT - 1;
                  rq.push_back(t);
                  e_rd_ack = 1'b1;
               end
               if (wr_start) begin
                  e_wr_ack = 1'b1;
                  e_wr_err = (int'(wr_addr) >= DEPTH);
                  if (!e_wr_err) mm[wr_addr] = merge(mm[wr_addr], wr_data, wr_strb);
               end
            end else begin
               since_rel++;
               if (since_rel == DEPTH) begin
                  rdy_m = 1'b1;
                  for (int a = 0; a < DEPTH; a++) mm[a] = INIT;
               end
            end
         end
      end
   end

   // per-cycle compare; also logs every completion seen for the directed checks
   logic [DW-1:0] rd_log[$];
   logic          err_log[$];

   initial begin
      forever begin
         @(negedge clk);
         begin
            logic cpl_e;
            logic [8:0] exp_ctrl, act_ctrl;
            cpl_e    = (rq.size() > 0) && (rq[0].due == cyc);
            exp_ctrl = {rdy_m, rdy_m, rdy_m, e_wr_ack, e_wr_ack, e_wr_err, e_rd_ack, cpl_e,
                        cpl_e ? rq[0].err : 1'b0};
            act_ctrl = {wr_ready, rd_ready, init_done, wr_ack, wr_cpl, wr_err, rd_ack, rd_cpl, rd_err};
            chk("ctrl", 64'(act_ctrl), 64'(exp_ctrl));
            chk("rd_data", 64'(rd_data), cpl_e ? 64'(rq[0].data) : 64'd0);
            if (rd_cpl) begin
               rd_log.push_back(rd_data);
               err_log.push_back(rd_err);
            end
         end
      end
   end

   // driver tasks
   task automatic drive(input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [3:0] ws, input logic r, input logic [AW-1:0] ra);
      @(posedge clk);
      #2;
      wr_start = w; wr_addr = wa; wr_data = wd; wr_strb = ws;
      rd_start = r; rd_addr = ra;
   endtask

   task automatic idle();
      drive(1'b0, '0, '0, '0, 1'b0, '0);
   endtask

   task automatic wait_ready(input string name);
      int n;
      n = 0;
      while (n <= DEPTH + 20) begin
         @(negedge clk);
         if (rd_ready) break;
         n++;
         #1;
         wr_start = ($urandom_range(0, 1) == 1); wr_addr = AW'($urandom_range(0, 15));
         wr_data  = $urandom; wr_strb = 4'($urandom_range(0, 15));
         rd_start = ($urandom_range(0, 1) == 1); rd_addr = AW'($urandom_range(0, 15));
      end
      wr_start = 1'b0; rd_start = 1'b0;
      chk(name, 64'(n), 64'(DEPTH));
   endtask

   task automatic write_lit(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                            input logic exp_err);
      drive(1'b1, a, d, s, 1'b0, '0);
      idle();
      @(negedge clk);
      chk("wr_ack_cpl_err", 64'({wr_ack, wr_cpl, wr_err}), 64'({2'b11, exp_err}));
   endtask

   task automatic read_lit(input string name, input logic [AW-1:0] a, input logic [DW-1:0] exp_d,
                           input logic exp_err);
      int n;
      drive(1'b0, '0, '0, '0, 1'b1, a);
      idle();
      n = 1;
      @(negedge clk);
      while (!rd_cpl && n < 10) begin
         n++;
         @(negedge clk);
      end
      chk({name, "_lat"}, 64'(n), 64'(LAT));
      chk({name, "_data"}, 64'(rd_data), 64'(exp_d));
      chk({name, "_err"}, 64'(rd_err), 64'(exp_err));
   endtask

   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog timeout");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      int base;
      #1 rst = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      wait_ready("init_cycles");

      read_lit("init_rd5", 8'd5, INIT, 1'b0);

      write_lit(8'd3, 32'hDEADBEEF, 4'hF, 1'b0);
      write_lit(8'd3, 32'h0000AA00, 4'h2, 1'b0);
      read_lit("strb_rd3", 8'd3, 32'hDEADAAEF, 1'b0);
      write_lit(8'd3, 32'h12345678, 4'h0, 1'b0);
      read_lit("strb0_rd3", 8'd3, 32'hDEADAAEF, 1'b0);

      write_lit(8'd1, 32'h11, 4'hF, 1'b0);
      write_lit(8'd2, 32'h22, 4'hF, 1'b0);
      write_lit(8'd3, 32'h33, 4'hF, 1'b0);
      base = rd_log.size();
      drive(1'b0, '0, '0, '0, 1'b1, 8'd1);
      drive(1'b0, '0, '0, '0, 1'b1, 8'd2);
      drive(1'b0, '0, '0, '0, 1'b1, 8'd3);
      idle();
      repeat (6) @(negedge clk);
      chk("burst_count", 64'(rd_log.size() - base), 64'd3);
      if (rd_log.size() - base == 3) begin
         chk("burst_0", 64'(rd_log[base]), 64'h11);
         chk("burst_1", 64'(rd_log[base+1]), 64'h22);
         chk("burst_2", 64'(rd_log[base+2]), 64'h33);
      end

      write_lit(8'hF0, 32'hFF, 4'hF, 1'b1);
      read_lit("oor_rd", 8'hF0, 32'h0, 1'b1);
      read_lit("last_rd", 8'hC7, INIT, 1'b0);

      write_lit(8'd7, 32'h11111111, 4'hF, 1'b0);
      drive(1'b1, 8'd7, 32'h22222222, 4'hF, 1'b1, 8'd7);
      idle();
      base = rd_log.size();
      repeat (LAT + 1) @(negedge clk);
      chk("coll_count", 64'(rd_log.size() - base), 64'd1);
      if (rd_log.size() > base) begin
`ifdef MXBUS_SRAM_BYPASS_EN
         chk("coll_data", 64'(rd_log[base]), 64'h22222222);
`else
         chk("coll_data", 64'(rd_log[base]), 64'h11111111);
`endif
      end
      read_lit("after_coll", 8'd7, 32'h22222222, 1'b0);

      // reset with a read in flight
      base = rd_log.size();
      drive(1'b0, '0, '0, '0, 1'b1, 8'd7);
      idle();
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rst_outs", 64'({wr_ready, rd_ready, init_done, wr_ack, wr_cpl, wr_err, rd_ack, rd_cpl,
                           rd_err, rd_data}), 64'd0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      wait_ready("reinit_cycles");
      chk("dropped_cpl", 64'(rd_log.size() - base), 64'd0);
      read_lit("reinit_rd7", 8'd7, INIT, 1'b0);

      // randomized traffic, biased to a small address window for collisions
      for (int i = 0; i < 400; i++) begin
         logic [AW-1:0] wa, ra;
         wa = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 255)) : AW'($urandom_range(0, 15));
         ra = ($urandom_range(0, 3) == 0) ? wa :
              (($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 255)) : AW'($urandom_range(0, 15)));
         drive(($urandom_range(0, 1) == 1), wa, $urandom, 4'($urandom_range(0, 15)),
               ($urandom_range(0, 1) == 1), ra);
      end
      idle();
      repeat (LAT + 4) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mxbus_sram_ctrl.md
Name: mxbus_sram_ctrl

Overview:
Parametrised MX Bus single-clock dual-port RAM slave. It is the successor to the basic MX Bus RAM slave and adds:
- separate DEPTH and ADDR_WIDTH
- byte-lane write strobes
- pipelined reads with configurable latency
- out-of-range error reporting
- a post-reset hardware init sweep in place of a one-cycle array clear

It sits behind the BIU as general-purpose scratch and data memory.

Parameters:
ADDR_WIDTH, 8, address bus width.
DATA_WIDTH, 32, data width; must be a multiple of 8.
DEPTH, 256, number of words implemented; 1..2**ADDR_WIDTH.
RD_LATENCY, 1, cycles from read start to read completion; 1..4.
INIT_VALUE, 0, word value written to every location during the init sweep.

Ports:
clk  input  1  clock, all logic on rising edge.
rst  input  1  reset; asynchronous, active-low.
s0_wr_txn_start  input  1  write request, one-cycle pulse per transaction.
s0_wr_addr  input  ADDR_WIDTH  write word address.
s0_wr_data  input  DATA_WIDTH  write data.
s0_wr_strb  input  DATA_WIDTH/8  byte-lane enables; bit i covers data[8i+7:8i].
s0_wr_ready  output  1  slave can accept a write.
s0_wr_txn_ack  output  1  write accepted.
s0_wr_txn_cpl  output  1  write completed.
s0_wr_err  output  1  write address out of range; valid with cpl.
s0_rd_txn_start  input  1  read request, one-cycle pulse per transaction.
s0_rd_addr  input  ADDR_WIDTH  read word address.
s0_rd_data  output  DATA_WIDTH  read data; valid with cpl.
s0_rd_ready  output  1  slave can accept a read.
s0_rd_txn_ack  output  1  read accepted.
s0_rd_txn_cpl  output  1  read data valid.
s0_rd_err  output  1  read address out of range; valid with cpl.
init_done  output  1  init sweep finished.

Behaviour:
- Reset (rst=0): all outputs 0 immediately; FSM to INIT; init counter 0; read pipeline valid bits cleared. Memory contents are not reset directly.
- FSM states are INIT and RUN.
- INIT:
  - each cycle, mem[cnt] <= INIT_VALUE and cnt++.
  - after DEPTH cycles go to RUN; init_done, s0_wr_ready and s0_rd_ready rise together, registered.
  - starts during INIT are ignored: no ack, no cpl, no memory effect.
- RUN: stays in RUN until reset; both readies held 1.
- Write, accepted when start=1 in RUN:
  - memory updates at the start edge, only lanes with strb=1.
  - s0_wr_txn_ack and s0_wr_txn_cpl pulse together for 1 cycle, the cycle after start.
  - a new write is accepted every cycle.
  - strb=0 is legal: no memory change, normal ack/cpl.
- Read, accepted when start=1 in RUN:
  - address and memory word are sampled at the start edge, then pass through a RD_LATENCY-stage valid/data pipeline.
  - s0_rd_txn_ack pulses the cycle after start.
  - s0_rd_txn_cpl and s0_rd_data appear RD_LATENCY cycles after the start edge; for RD_LATENCY=1, ack and cpl coincide.
  - one read per cycle; completions in order; no stalls.
  - s0_rd_data is 0 whenever cpl=0.
- Out of range (addr >= DEPTH):
  - write: memory untouched; ack/cpl as normal with s0_wr_err=1.
  - read: data 0 and s0_rd_err=1 with cpl.
  - err outputs are 0 whenever the matching cpl is 0.
- Read/write ordering:
  - a read starting in any cycle after a write's start edge returns the written data.
  - same-cycle read and write to the same address: see Optional Feature.
- Reset mid-operation: in-flight reads are dropped with no cpl, readies drop, and a full INIT sweep reruns.
- Illegal DATA_WIDTH, DEPTH or RD_LATENCY values: elaboration error.

Optional Feature:
MXBUS_SRAM_BYPASS_EN.
- Defined: a same-cycle read and write to the same in-range address returns the written data, merged per strobe over the old word (write-first forwarding into pipeline stage 0).
- Undefined: the read returns the old word (read-first); no forwarding logic is built.

Test Plan:
1. DEPTH=16, INIT_VALUE=0xA5A5A5A5, release reset -> readies/init_done low 16 cycles then high; read addr 5 -> data 0xA5A5A5A5, err 0.
2. Write 0xDEADBEEF to addr 3, strb 0xF; then write 0x0000AA00, strb 0x2; read addr 3 -> 0xDEADAAEF; each write ack+cpl one cycle after start.
3. RD_LATENCY=3, reads of addr 1,2,3 (holding 0x11,0x22,0x33) on consecutive cycles t,t+1,t+2 -> ack at t+1..t+3; cpl with 0x11,0x22,0x33 at t+3,t+4,t+5.
4. DEPTH=200, write 0xFF to addr 0xF0 -> cpl with wr_err=1, memory unchanged; read addr 0xF0 -> data 0, rd_err=1; read addr 0xC7 -> err 0.
5. Addr 7 holds 0x11111111; same-cycle write 0x22222222 (strb 0xF) and read of addr 7 -> read returns 0x11111111 without the macro, 0x22222222 with MXBUS_SRAM_BYPASS_EN.
6. RD_LATENCY=4, assert rst=0 two cycles after a read start -> all outputs 0 immediately, no cpl ever for that read; after release, readies return after DEPTH cycles.
